// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the FIFO write port among
// N_REQ producers, granting bounded bursts and stalling on the FIFO full flag.
module fifo_wr_arbiter #(
   parameter int N_REQ      = 4,
   parameter int Data_Width = 8,
   parameter int BURST_LEN  = 4,
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int BW = $clog2(BURST_LEN) + 1
) (
   input  logic                        wclk,
   input  logic                        w_rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*Data_Width-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        full,
   output logic                        w_en,
   output logic [Data_Width-1:0]       data_in,
   output logic [GW-1:0]               grant_id,
   output logic                        busy,
   output logic [GW-1:0]               dbg_rr_ptr,
   output logic [BW-1:0]               dbg_beat_cnt
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [GW-1:0] LAST_ID   = GW'(N_REQ - 1);

   state_t                state;
   logic [GW-1:0]         rr_ptr;
   logic [BW-1:0]         beat_cnt;
   logic [Data_Width-1:0] data_arr [N_REQ];
   logic                  found;
   logic [GW-1:0]         winner;
   int                    best_dist;
   logic                  grant_valid;
   logic [GW-1:0]         next_ptr;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         data_arr[i] = req_data[i*Data_Width +: Data_Width];
      end
   end

   // Winner is the valid producer with the smallest forward distance from rr_ptr.
   always_comb begin
      found     = 1'b0;
      winner    = rr_ptr;
      best_dist = N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && (((i + N_REQ - int'(rr_ptr)) % N_REQ) < best_dist)) begin
            found     = 1'b1;
            winner    = GW'(i);
            best_dist = (i + N_REQ - int'(rr_ptr)) % N_REQ;
         end
      end
   end

   assign grant_valid = req_valid[grant_id];
   assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

   // Handshake: word i moves on a wclk edge where req_valid[i] & req_ready[i];
   // only the grantee can see ready, it drops while full, and reset forces it low.
   always_comb begin
      req_ready = '0;
      w_en      = 1'b0;
      data_in   = data_arr[grant_id];
      if (state == BURST && !w_rst) begin
         req_ready[grant_id] = !full;
         w_en                = grant_valid & !full;
      end
   end

   always_ff @(posedge wclk) begin
      if (w_rst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= winner;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (!grant_valid) begin
                  state    <= IDLE;
                  rr_ptr   <= next_ptr;
                  beat_cnt <= '0;
               end else if (!full) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state    <= IDLE;
                     rr_ptr   <= next_ptr;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy         = (state == BURST);
   assign dbg_rr_ptr   = rr_ptr;
   assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model with a write scoreboard.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 4;

   logic          wclk = 1'b0;
   logic          w_rst;
   logic          full;
   logic [N-1:0]  req_valid;
   logic [DW-1:0] pdata [N];
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          w_en;
   logic [DW-1:0] data_in;
   logic [1:0]    grant_id;
   logic          busy;
   logic [1:0]    dbg_rr_ptr;
   logic [2:0]    dbg_beat_cnt;

   always #5 wclk = ~wclk;

   assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

   fifo_wr_arbiter #(.N_REQ(N), .Data_Width(DW), .BURST_LEN(BL)) dut (
      .wclk(wclk), .w_rst(w_rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .full(full), .w_en(w_en), .data_in(data_in),
      .grant_id(grant_id), .busy(busy), .dbg_rr_ptr(dbg_rr_ptr),
      .dbg_beat_cnt(dbg_beat_cnt)
   );

   typedef struct {
      logic          rst;
      logic [N-1:0]  valid;
      logic          full;
      logic [DW-1:0] d2;
      logic          e_wen;
      logic [N-1:0]  e_ready;
      logic          e_busy;
      logic [1:0]    e_gid;
      logic [DW-1:0] e_din;
   } vec_t;

   vec_t vecs [16];
   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] exp_q [$];
   logic [1:0]    grants [$];
   logic [N-1:0]  acc;
   int            words [N];
   int            g;
   int            k4;
   logic          prev_busy;

   // reference model state
   logic          m_act;
   logic [1:0]    m_g;
   logic [1:0]    m_gid;
   int            m_rr;
   int            m_beats;
   logic          m_wen;
   logic [N-1:0]  m_ready;
   logic [1:0]    cand;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      w_rst = 1'b1;
      req_valid = '0;
      full = 1'b0;
      tick();
      w_rst = 1'b0;
   endtask

   initial begin
      w_rst = 1'b1;
      full = 1'b0;
      req_valid = '0;
      pdata[0] = 8'hA0; pdata[1] = 8'hA1; pdata[2] = 8'h00; pdata[3] = 8'hA3;

      //          rst   valid  full  d2     wen   ready  busy  gid    din
      vecs[0]  = '{1'b1, 4'hF, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
      vecs[1]  = '{1'b1, 4'hF, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
      vecs[2]  = '{1'b0, 4'hF, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
      vecs[3]  = '{1'b0, 4'hF, 1'b0, 8'h00, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
      vecs[4]  = '{1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h1, 1'b1, 2'd0, 8'hA0};
      vecs[5]  = '{1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
      vecs[6]  = '{1'b0, 4'h4, 1'b0, 8'h10, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
      vecs[7]  = '{1'b0, 4'h4, 1'b0, 8'h10, 1'b1, 4'h4, 1'b1, 2'd2, 8'h10};
      vecs[8]  = '{1'b0, 4'h4, 1'b0, 8'h11, 1'b1, 4'h4, 1'b1, 2'd2, 8'h11};
      vecs[9]  = '{1'b0, 4'h4, 1'b0, 8'h12, 1'b1, 4'h4, 1'b1, 2'd2, 8'h12};
      vecs[10] = '{1'b0, 4'h4, 1'b0, 8'h13, 1'b1, 4'h4, 1'b1, 2'd2, 8'h13};
      vecs[11] = '{1'b0, 4'h4, 1'b0, 8'h14, 1'b0, 4'h0, 1'b0, 2'd2, 8'h00};
      vecs[12] = '{1'b0, 4'h4, 1'b0, 8'h14, 1'b1, 4'h4, 1'b1, 2'd2, 8'h14};
      vecs[13] = '{1'b0, 4'h4, 1'b0, 8'h15, 1'b1, 4'h4, 1'b1, 2'd2, 8'h15};
      vecs[14] = '{1'b0, 4'h0, 1'b0, 8'h15, 1'b0, 4'h4, 1'b1, 2'd2, 8'h15};
      vecs[15] = '{1'b0, 4'h0, 1'b0, 8'h15, 1'b0, 4'h0, 1'b0, 2'd2, 8'h00};

      tick();

      // reset hold, first grant, single-producer bursts
      for (int r = 0; r < 16; r++) begin
         w_rst = vecs[r].rst;
         req_valid = vecs[r].valid;
         full = vecs[r].full;
         pdata[2] = vecs[r].d2;
         #2;
         check($sformatf("vec%0d_w_en", r), w_en, vecs[r].e_wen);
         check($sformatf("vec%0d_ready", r), req_ready, vecs[r].e_ready);
         check($sformatf("vec%0d_busy", r), busy, vecs[r].e_busy);
         check($sformatf("vec%0d_gid", r), grant_id, vecs[r].e_gid);
         if (vecs[r].e_busy) check($sformatf("vec%0d_din", r), data_in, vecs[r].e_din);
         tick();
      end

      // all producers continuous: 4 writes then 1 bubble, grants 0,1,2,3,0
      do_reset();
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         words[i] = 0;
         pdata[i] = 8'(i << 4);
      end
      for (int c = 0; c < 25; c++) begin
         #2;
         check("t3_w_en", w_en, (c % 5) != 0);
         if ((c % 5) != 0) begin
            g = (c / 5) % 4;
            check("t3_grant", grant_id, g);
            check("t3_data", data_in, (g << 4) | (words[g] & 15));
         end
         acc = req_valid & req_ready;
         tick();
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               words[i]++;
               pdata[i] = 8'((i << 4) | (words[i] & 15));
            end
         end
      end
      check("t3_words_p0", words[0], 8);
      for (int i = 1; i < N; i++) check($sformatf("t3_words_p%0d", i), words[i], 4);

      // full stall in the middle of a producer-1 burst
      do_reset();
      req_valid = 4'b0010;
      pdata[1] = 8'h40;
      k4 = 0;
      for (int c = 0; c < 9; c++) begin
         full = (c >= 3 && c <= 5);
         #2;
         check("t4_w_en", w_en, (c == 1 || c == 2 || c == 6 || c == 7));
         check("t4_ready1", req_ready[1], (c >= 1 && c <= 7 && !full));
         if (c == 1 || c == 2 || c == 6 || c == 7) begin
            check("t4_data", data_in, 8'h40 + k4);
            k4++;
         end
         if (full) check("t4_beat_hold", dbg_beat_cnt, 2);
         acc = req_valid & req_ready;
         tick();
         if (acc[1]) pdata[1] = pdata[1] + 8'd1;
      end
      full = 1'b0;

      // early release by producer 0 with 1 and 3 waiting
      do_reset();
      req_valid = 4'b1011;
      #2; check("t5_idle", busy, 0); tick();
      #2; check("t5_gid0", grant_id, 0); check("t5_wen0", w_en, 1); tick();
      req_valid[0] = 1'b0;
      #2; check("t5_release_wen", w_en, 0); tick();
      req_valid = 4'b1011;
      prev_busy = 1'b0;
      grants.delete();
      for (int c = 0; c < 18; c++) begin
         #2;
         if (c == 0) begin
            check("t5_rr_ptr", dbg_rr_ptr, 1);
            check("t5_idle2", busy, 0);
         end
         if (busy && !prev_busy) grants.push_back(grant_id);
         prev_busy = busy;
         tick();
      end
      check("t5_n_grants", grants.size() >= 3, 1);
      if (grants.size() >= 3) begin
         check("t5_grant_a", grants[0], 1);
         check("t5_grant_b", grants[1], 3);
         check("t5_grant_c", grants[2], 0);
      end

      // reset pulse at beat 2 of a producer-3 burst
      do_reset();
      req_valid = 4'b1000;
      tick();
      #2; check("t6_gid3", grant_id, 3); check("t6_wen_a", w_en, 1); tick();
      #2; check("t6_wen_b", w_en, 1); tick();
      req_valid = 4'b1010;
      w_rst = 1'b1;
      #2; check("t6_rst_wen", w_en, 0); check("t6_rst_ready", req_ready, 0); tick();
      w_rst = 1'b0;
      #2; check("t6_idle", busy, 0); check("t6_rr_ptr", dbg_rr_ptr, 0); tick();
      #2; check("t6_busy", busy, 1); check("t6_lowest", grant_id, 1); tick();

      // randomized traffic against the reference model
      do_reset();
      m_act = 1'b0; m_g = '0; m_gid = '0; m_rr = 0; m_beats = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) pdata[i] = 8'($urandom);
      for (int c = 0; c < 800; c++) begin
         w_rst = ($urandom_range(0, 79) == 0);
         full = ($urandom_range(0, 3) == 0);
         #2;
         m_wen = 1'b0;
         m_ready = '0;
         if (m_act && !w_rst) begin
            m_ready[m_g] = !full;
            m_wen = req_valid[m_g] && !full;
         end
         check("rnd_w_en", w_en, m_wen);
         check("rnd_ready", req_ready, m_ready);
         check("rnd_busy", busy, m_act);
         check("rnd_gid", grant_id, m_gid);
         check("rnd_rr_ptr", dbg_rr_ptr, m_rr);
         if (m_wen) exp_q.push_back(pdata[m_g]);
         if (w_en) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rnd_unexpected_write: got %0h expected none", data_in);
            end else begin
               check("rnd_data", data_in, exp_q.pop_front());
            end
         end
         if (w_rst) begin
            m_act = 1'b0; m_gid = '0; m_rr = 0; m_beats = 0;
         end else if (!m_act) begin
            for (int k = 0; k < N; k++) begin
               cand = 2'((m_rr + k) % N);
               if (!m_act && req_valid[cand]) begin
                  m_act = 1'b1; m_g = cand; m_gid = cand; m_beats = 0;
               end
            end
         end else if (!req_valid[m_g]) begin
            m_act = 1'b0;
            m_rr = (int'(m_g) + 1) % N;
         end else if (!full) begin
            m_beats++;
            if (m_beats == BL) begin
               m_act = 1'b0;
               m_rr = (int'(m_g) + 1) % N;
            end
         end
         acc = req_valid & req_ready;
         tick();
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               pdata[i] = 8'($urandom);
               req_valid[i] = ($urandom_range(0, 3) != 0);
            end else if (!req_valid[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               pdata[i] = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      check("rnd_sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the asynchronous FIFO's single write port among `N_REQ` producers in the write clock domain. Each producer presents words over a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, drives the FIFO's `w_en`/`data_in`, and back-pressures producers using the FIFO `full` flag. It sits between the producer agents and the FIFO top, entirely on `wclk`.

## Interface
- `N_REQ`, 4: number of producers (2..16).
- `Data_Width`, 8: FIFO data width.
- `BURST_LEN`, 4: maximum beats per grant (1..256).
- `wclk` in 1: write-domain clock; all state updates on its rising edge.
- `w_rst` in 1: reset, synchronous, active-high.
- `req_valid` in `N_REQ`: bit i high means producer i has a word.
- `req_data` in `N_REQ*Data_Width`: producer i's word occupies bits [i*Data_Width +: Data_Width].
- `req_ready` out `N_REQ`: one-hot or zero; word i is accepted on an edge where `req_valid[i] & req_ready[i]`.
- `full` in 1: FIFO full flag from the write pointer handler.
- `w_en` out 1: FIFO write enable.
- `data_in` out `Data_Width`: FIFO write data.
- `grant_id` out `max(1,$clog2(N_REQ))`: index of the current or last grantee.
- `busy` out 1: high while in the BURST state.

## Operation
- Registered state: `state` (IDLE, BURST), `grant_id`, `rr_ptr` (same width as `grant_id`), `beat_cnt` (`$clog2(BURST_LEN)+1` bits).
- **IDLE**
  - If any `req_valid` bit is high, select the first set bit scanning `rr_ptr`, `rr_ptr+1`, … modulo `N_REQ`.
  - Next edge: `grant_id` = winner, `beat_cnt` = 0, state = BURST.
  - No transfer occurs in an IDLE cycle, so arbitration costs one bubble cycle.
  - With no valid bits set, the block stays in IDLE.
- **BURST**, with g = `grant_id`:
  - `req_ready[g] = !full`; all other `req_ready` bits are 0.
  - `w_en = req_valid[g] & !full`.
  - `data_in = req_data[g]` (driven even when `w_en` = 0).
  - On a transfer (`w_en` = 1), `beat_cnt` increments.
  - Exit to IDLE when either:
    - a transfer occurs with `beat_cnt == BURST_LEN-1` (last beat written), or
    - `req_valid[g]` is 0 (release; no transfer that cycle).
  - On exit: `rr_ptr` = (g+1) mod `N_REQ`, `beat_cnt` = 0.
  - `full` high: no transfer, `beat_cnt` holds, state holds. A full FIFO never ends a burst.
- **Outputs:** `w_en`, `req_ready` and `data_in` are combinational from state and inputs. `w_en` and every `req_ready` bit are additionally gated by `!w_rst`, so no word is written or accepted in any cycle where reset is high.
- **Producer rule:** hold `req_data` stable while `req_valid & !req_ready`. Lowering `req_valid` forfeits the remaining burst.
- **Non-grantees:** `req_valid` changes on non-granted producers have no effect until the next IDLE cycle.
- **BURST_LEN=1:** every grant carries exactly one beat, so a busy producer sees alternating IDLE/BURST cycles.
- **Wrap-around:** `rr_ptr` wraps from `N_REQ-1` to 0. For non-power-of-two `N_REQ`, the modulo is explicit and `rr_ptr` never holds an index ≥ `N_REQ`.

## Timing
- **Reset values** after an edge with `w_rst`=1: state IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `busy`=0. Combinationally, `w_en`=0 and `req_ready`=0. `data_in` = `req_data[0]` (don't-care).
- **Reset mid-burst:** the transfer is suppressed in the reset cycle, and the next edge returns to IDLE. A partially sent burst is not resumed; the producer retries.
- **Latency:** a request in IDLE at edge n is granted at edge n+1. The first word is written at edge n+2 if not full.
- **Throughput:** one burst of `BURST_LEN` beats per `BURST_LEN+1` cycles under continuous demand with the FIFO never full.
- **`full` timing:** `full` is the registered flag sampled in the same cycle. The write that fills the FIFO is the last write; `full` rises after that edge and blocks the next write.

## Test plan
1. **Reset:** assert `w_rst` for 2 cycles with all `req_valid`=1 -> `w_en`=0, `req_ready`=0, `busy`=0, `grant_id`=0 throughout; first grant after release goes to producer 0.
2. **Single producer:** producer 2 sends 0x10..0x15 (6 words), `BURST_LEN`=4, FIFO never full -> one idle cycle, then 4 writes 0x10..0x13, one idle cycle, then 2 writes 0x14,0x15, then IDLE; `grant_id`=2 during both bursts.
3. **All producers continuous:** all 4 producers valid continuously -> grant order 0,1,2,3,0; `w_en` pattern is 4 high, 1 low, repeating; each producer gets exactly 4 words per round.
4. **Full stall:** `full` raised after beat 2 of a producer-1 burst for 3 cycles -> `w_en`=0 and `req_ready[1]`=0 for those 3 cycles, `beat_cnt` holds at 2; beats 3 and 4 then follow in order with no loss or duplication.
5. **Early release:** producer 0 drops `req_valid` after 1 beat while producers 1 and 3 are waiting -> return to IDLE, `rr_ptr`=1, next grant to producer 1, then 3, then 0.
6. **Reset mid-burst:** `w_rst` pulsed for 1 cycle at beat 2 of a producer-3 burst -> no `w_en` in the reset cycle; state IDLE and `rr_ptr`=0 afterwards; next grant goes to the lowest valid index.
